// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, TX FIFO and
// a serialising FSM that chains frames back-to-back while the FIFO holds data.
module uart_tx_mmio #(
  parameter logic [10:0] BASE       = 11'h440,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [10:0] address,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] read_data,
  output logic        TX,
  output logic        tx_idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [10:0] ADDR_DATA = BASE;
  localparam logic [10:0] ADDR_STAT = BASE + 11'd4;
  localparam logic [10:0] ADDR_DIV  = BASE + 11'd8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_d;
  logic             overflow;
  logic [15:0]      div_reg, bit_div, bit_div_d, cyc_cnt, cyc_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d, pop, push, bit_end, busy;
  logic             fifo_empty, fifo_full, data_wr, stat_wr, div_wr;
  logic             unused_bits;

  // A programmed divisor of 0 would stall the bit counter, so clamp to 1.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  assign data_wr     = MemWrite && (address == ADDR_DATA);
  assign stat_wr     = MemWrite && (address == ADDR_STAT);
  assign div_wr      = MemWrite && (address == ADDR_DIV);
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FULL_CNT);
  assign push        = data_wr && (!fifo_full || pop);
  assign bit_end     = (cyc_cnt == bit_div - 16'd1);
  assign busy        = (state != IDLE);
  assign unused_bits = ^write_data[31:16];

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CNT_W'(1);
    else if (pop && !push) count_d = count - CNT_W'(1);
  end

  always_comb begin
    state_d   = state;
    cyc_cnt_d = cyc_cnt + 16'd1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    bit_div_d = bit_div;
    tx_d      = TX;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_d      = 1'b1;
        cyc_cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr];
          bit_div_d = eff_div(div_reg);
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shift_d   = shift >> 1;
            tx_d      = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_cnt_d = '0;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_mem[rd_ptr];
            bit_div_d = eff_div(div_reg);
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_idx  <= '0;
      bit_div  <= 16'd1;
      TX       <= 1'b1;
      tx_idle  <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div_reg  <= DIV_RESET;
    end else begin
      state   <= state_d;
      cyc_cnt <= cyc_cnt_d;
      bit_idx <= bit_idx_d;
      bit_div <= bit_div_d;
      TX      <= tx_d;
      tx_idle <= (count_d == '0) && (state_d == IDLE);
      count   <= count_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (data_wr && fifo_full && !pop)  overflow <= 1'b1;
      else if (stat_wr && write_data[3]) overflow <= 1'b0;
      if (div_wr) div_reg <= write_data[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    shift <= shift_d;
    if (push) fifo_mem[wr_ptr] <= write_data[7:0];
  end

  always_comb begin
    read_data = '0;
    if (MemRead) begin
      if (address == ADDR_STAT)
        read_data = {24'd0, 4'(count), overflow, busy, fifo_empty, fifo_full};
      else if (address == ADDR_DIV)
        read_data = {16'd0, div_reg};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomized bench for uart_tx_mmio; TX waveforms are compared
// frame by frame against an ideal 8N1 bit schedule built from the byte stream.
module tb_uart_tx_mmio;

  localparam logic [10:0] BASE   = 11'h440;
  localparam logic [10:0] A_DATA = BASE;
  localparam logic [10:0] A_STAT = BASE + 11'd4;
  localparam logic [10:0] A_DIV  = BASE + 11'd8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] address = '0;
  logic [31:0] write_data = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] read_data;
  logic        TX;
  logic        tx_idle;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   burst [0:9];
  logic [255:0] obs   [0:9];

  uart_tx_mmio #(.BASE(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .CLK(CLK), .RESET(RESET), .address(address), .write_data(write_data),
    .MemWrite(MemWrite), .MemRead(MemRead), .read_data(read_data),
    .TX(TX), .tx_idle(tx_idle)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [10:0] a, input logic [31:0] d);
    address = a; write_data = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic read_reg(input logic [10:0] a, output logic [31:0] d);
    address = a; MemRead = 1'b1;
    #1;
    d = read_data;
    MemRead = 1'b0;
  endtask

  // Ideal 8N1 line waveform for one byte: start 0, data LSB first, stop 1.
  function automatic logic [255:0] exp_frame(input logic [7:0] b, input int d);
    logic [255:0] v;
    int slot;
    v = '0;
    for (int s = 0; s < 10 * d; s++) begin
      slot = s / d;
      v[s] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
    end
    return v;
  endfunction

  // Writes nw bytes on consecutive cycles from idle; one byte leaves at once,
  // so at most FIFO_DEPTH+1 = 9 survive. Optionally writes DIV at cycle mid_c.
  task automatic run_burst(input string tag, input int nw, input int d,
                           input int mid_c, input logic [15:0] mid_div);
    int nf, total, t, cnt;
    logic [31:0] rd, exp_st;
    nf = (nw > 9) ? 9 : nw;
    total = 10 * d * nf;
    for (int f = 0; f < 10; f++) obs[f] = '0;
    for (int c = 0; c <= total; c++) begin
      MemWrite = 1'b0;
      if (c < nw) begin
        address = A_DATA; write_data = {24'd0, burst[c]}; MemWrite = 1'b1;
      end else if (c == mid_c) begin
        address = A_DIV; write_data = {16'd0, mid_div}; MemWrite = 1'b1;
      end
      tick();
      MemWrite = 1'b0;
      if (c >= 1) begin
        t = c - 1;
        obs[t / (10 * d)][t % (10 * d)] = TX;
      end
      if (c == nw - 1) begin
        cnt = (nw == 1) ? 1 : ((nw - 1 > 8) ? 8 : nw - 1);
        exp_st = (cnt << 4) | ((nw > 9) ? 32'h8 : 32'h0) | ((nw > 1) ? 32'h4 : 32'h0)
               | ((cnt == 8) ? 32'h1 : 32'h0);
        read_reg(A_STAT, rd);
        check({tag, "_status_fill"}, rd, exp_st);
      end
    end
    for (int f = 0; f < nf; f++)
      check($sformatf("%s_frame%0d", tag, f), obs[f], exp_frame(burst[f], d));
    tick();
    check({tag, "_tx_idle"}, tx_idle, 1);
    check({tag, "_tx_high"}, TX, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen_low;
    int          dw, d, nw;

    // Reset values
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    check("rst_tx", TX, 1);
    check("rst_tx_idle", tx_idle, 1);
    read_reg(A_STAT, rd); check("rst_status", rd, 32'h2);
    read_reg(A_DIV, rd);  check("rst_div", rd, 32'd434);

    // Single frame 0xA5 at DIV=4
    write_reg(A_DIV, 32'd4);
    burst[0] = 8'hA5;
    run_burst("single", 1, 4, -1, 16'd0);
    read_reg(A_STAT, rd); check("single_status", rd, 32'h2);

    // Overflow: ten bytes, the tenth is dropped
    write_reg(A_DIV, 32'd2);
    for (int i = 0; i < 10; i++) burst[i] = 8'(i);
    run_burst("ovf", 10, 2, -1, 16'd0);
    read_reg(A_STAT, rd); check("ovf_sticky", rd, 32'hA);
    write_reg(A_STAT, 32'hFFFF_FFF7);
    read_reg(A_STAT, rd); check("ovf_keep", rd, 32'hA);
    write_reg(A_STAT, 32'h8);
    read_reg(A_STAT, rd); check("ovf_clear", rd, 32'h2);

    // Divisor change during a frame applies to the next frame only
    write_reg(A_DIV, 32'd8);
    burst[0] = 8'h55;
    run_burst("divchg_a", 1, 8, 30, 16'd3);
    read_reg(A_DIV, rd); check("divchg_readback", rd, 32'd3);
    burst[0] = 8'hFF;
    run_burst("divchg_b", 1, 3, -1, 16'd0);

    // Reset in the middle of data bit 4 of the first of three frames
    write_reg(A_DIV, 32'd10);
    write_reg(A_DATA, 32'h0F);
    write_reg(A_DATA, 32'h3C);
    write_reg(A_DATA, 32'hC3);
    for (int i = 0; i < 53; i++) tick();
    check("rstmid_bit4", TX, 0);
    RESET = 1'b1;
    tick();
    check("rstmid_tx", TX, 1);
    RESET = 1'b0;
    read_reg(A_STAT, rd); check("rstmid_status", rd, 32'h2);
    read_reg(A_DIV, rd);  check("rstmid_div", rd, 32'd434);
    seen_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (TX !== 1'b1) seen_low = 1'b1;
    end
    check("rstmid_no_frames", seen_low, 0);

    // Address decode
    write_reg(A_DIV, 32'd2);
    write_reg(BASE + 11'd12, 32'h77);
    write_reg(BASE + 11'd1, 32'h77);
    seen_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (TX !== 1'b1) seen_low = 1'b1;
    end
    check("dec_no_frame", seen_low, 0);
    read_reg(A_STAT, rd); check("dec_status", rd, 32'h2);
    address = A_STAT; MemRead = 1'b0; #1;
    check("dec_no_memread", read_data, 32'h0);
    read_reg(A_DATA, rd); check("dec_data_read", rd, 32'h0);
    read_reg(BASE + 11'd12, rd); check("dec_miss_read", rd, 32'h0);
    tick();

    // Randomized bursts; first iteration uses DIV=0, which must act as 1
    for (int it = 0; it < 6; it++) begin
      dw = (it == 0) ? 0 : $urandom_range(1, 5);
      d  = (dw == 0) ? 1 : dw;
      nw = (it == 1) ? 10 : $urandom_range(1, 10);
      for (int i = 0; i < 10; i++) burst[i] = 8'($urandom_range(0, 255));
      write_reg(A_DIV, 32'(dw));
      run_burst($sformatf("rnd%0d", it), nw, d, -1, 16'd0);
      read_reg(A_STAT, rd);
      check($sformatf("rnd%0d_status", it), rd, (nw > 9) ? 32'hA : 32'h2);
      write_reg(A_STAT, 32'h8);
      read_reg(A_DIV, rd);
      check($sformatf("rnd%0d_div", it), rd, 32'(dw));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter peripheral. It is a bus responder on the core's data-memory path: the memory controller decodes its address window and forwards store and load strobes to it. Bytes stored by software are queued in a TX FIFO and serialised as 8N1 frames on a single TX line. Status and baud-divisor registers are readable, so software can poll before writing.

Parameters:
BASE, 11'h440, byte address of the register window; the block decodes BASE+0, BASE+4, BASE+8.
FIFO_DEPTH, 8, TX FIFO entries; power of 2, range 2..8.
DIV_RESET, 434, reset value of the baud divisor (50 MHz / 115200).

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
address  in  11  byte address from the memory controller
write_data  in  32  store data
MemWrite  in  1  one-cycle store strobe
MemRead  in  1  load qualifier
read_data  out  32  load data, combinational
TX  out  1  serial output; idle high; registered
tx_idle  out  1  high when the FIFO is empty and the FSM is in IDLE; registered

Behaviour:
Register map:
- DATA @BASE+0, write-only: write_data[7:0] is pushed into the FIFO; reads return 0.
- STATUS @BASE+4, read: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow sticky, [7:4] FIFO count, [31:8] 0.
- STATUS write: a 1 in write_data[3] clears overflow; other bits are ignored.
- DIV @BASE+8, read/write: [15:0] bit period in CLK cycles; [31:16] read 0. A value of 0 is treated as 1.

Bus rules:
- Only an exact match on the full 11-bit address selects a register; other addresses are ignored on write and return 0 on read.
- read_data is 0 unless MemRead=1 and the address hits.
- Stores take effect on the CLK edge that samples MemWrite=1.

Reset (RESET=1 at an edge):
- TX=1, tx_idle=1, FIFO flushed (count=0), overflow=0, DIV=DIV_RESET, FSM=IDLE, all counters 0.
- Reset applied mid-frame aborts the frame; TX is 1 after that edge.

FIFO:
- Push when DATA is written and the FIFO is not full.
- Push while full: the byte is dropped and overflow is set.
- Push and pop in the same cycle: both happen; the count is unchanged. This also applies when the FIFO is full.
- Pop never occurs when the FIFO is empty.
- Read and write pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, STOP.
- IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor (bit_div = max(DIV,1)) and go to START. TX=0 is registered on that same edge.
- START: hold TX=0 for bit_div cycles, then go to DATA with TX=shift[0].
- DATA: each bit is held for bit_div cycles, sent LSB first; after bit 7 go to STOP with TX=1.
- STOP: hold TX=1 for bit_div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*bit_div cycles. Back-to-back frames have a start-to-start spacing of 10*bit_div cycles.

Divisor changes:
- A DIV write during a frame does not affect that frame; it is used from the next frame.

Latency:
- With the machine idle, a DATA write sampled at edge E0 enters the FIFO at E0. The FSM pops at E1, and TX falls after E1.

tx_idle:
- tx_idle = (FIFO empty) AND (FSM==IDLE), registered.

Test Plan:
- Reset values: assert RESET for 2 cycles. Require TX=1, tx_idle=1, a STATUS read returns 0x00000002, and a DIV read returns 434.
- Single frame: write DIV=4, then DATA=0xA5. TX falls 1 cycle after the DATA write. Required 4-cycle bit sequence: 0, 1,0,1,0,0,1,0,1, 1. tx_idle returns to 1 after 40 cycles.
- Overflow: DIV=2, then 10 consecutive DATA writes 0x00..0x09 starting from idle. The first byte is popped at once, so 0x00..0x08 are accepted and 0x09 is dropped. STATUS[3]=1 afterwards. Exactly 9 frames are emitted, 0x00..0x08, spaced 20 cycles start-to-start. Writing STATUS=0x8 clears STATUS[3].
- Divisor change mid-frame: DIV=8, write 0x55, write DIV=3 during the DATA state. The first frame lasts 80 cycles; a second byte 0xFF then lasts 30 cycles.
- Reset mid-frame: DIV=10, write 3 bytes, assert RESET during bit 4. Require TX=1 at the next edge, STATUS=0x2 and no further frames.
- Address decode: write 0x77 to BASE+12 and BASE+1. Require no frame and STATUS unchanged. A read with MemRead=0 at BASE+4 returns 0.
